if_id_pipe: RTL and testbench

//   Parametrised IF->ID pipeline register; successor to the fixed-width, always-advancing IF/ID latch.

---
 rtl/core_pkg.sv | 16 +
 rtl/pipe_skid.sv | 59 +++++
 rtl/if_id_pipe.sv | 73 +++++++
 tb/tb_if_id_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and payload layout for the fetch/decode boundary.
// Widths here are the defaults; modules re-derive widths from their own parameters.
package core_pkg;

    localparam int          DEF_PC_W     = 64;
    localparam int          DEF_INST_W   = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013; // addi x0, x0, 0

    // Field order matches the packing used on the skid buffer payload (pc in the MSBs).
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
        logic                  fault;
    } if_beat_t;

endpackage

// File: rtl/pipe_skid.sv
// Generic two-slot skid buffer with valid/ready on both sides and a synchronous flush.
// Upstream ready depends only on the skid register, so no combinational path from downstream ready.
module pipe_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_skid_valid
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_accept;
    logic w_leave;

    assign o_ready      = !r_skid_valid;
    assign o_valid      = r_main_valid;
    assign o_data       = r_main_data;
    assign o_skid_valid = r_skid_valid;

    assign w_accept = i_valid && !r_skid_valid;
    assign w_leave  = r_main_valid && i_ready;

    // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || (w_leave && !r_skid_valid)) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main_data <= i_data;
            end
        end else if (w_leave) begin
            // Skid is full here, so upstream was stalled and nothing arrives this edge.
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register: skid-buffered handshake, flush, NOP presentation when empty,
// fetch-fault passthrough, occupancy report and a saturating stall-cycle counter.
module if_id_pipe
    import core_pkg::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST),
    parameter int                STALL_CW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [PC_W-1:0]     if_pc,
    input  logic [INST_W-1:0]   if_inst,
    input  logic                if_fault,
    input  logic                flush,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_W-1:0]     id_pc,
    output logic [INST_W-1:0]   id_inst,
    output logic                id_fault,
    output logic [1:0]          occupancy,
    output logic [STALL_CW-1:0] stall_cnt
);

    localparam int DATA_W = PC_W + INST_W + 1;

    logic [DATA_W-1:0]   w_in_data;
    logic [DATA_W-1:0]   w_out_data;
    logic                w_main_valid;
    logic                w_skid_valid;
    logic [PC_W-1:0]     w_out_pc;
    logic [INST_W-1:0]   w_out_inst;
    logic                w_out_fault;
    logic [STALL_CW-1:0] r_stall_cnt;

    assign w_in_data = {if_pc, if_inst, if_fault};
    assign {w_out_pc, w_out_inst, w_out_fault} = w_out_data;

    pipe_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_valid      (if_valid),
        .o_ready      (if_ready),
        .i_data       (w_in_data),
        .o_valid      (w_main_valid),
        .i_ready      (id_ready),
        .o_data       (w_out_data),
        .o_skid_valid (w_skid_valid)
    );

    // The pc is left unmasked when empty; decode must ignore it without id_valid.
    assign id_valid  = w_main_valid;
    assign id_pc     = w_out_pc;
    assign id_inst   = w_main_valid ? w_out_inst : NOP_INST;
    assign id_fault  = w_main_valid && w_out_fault;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !id_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: reset, streaming, backpressure, flush, fault and stall counter.
module tb_if_id_pipe;

    localparam int PC_W     = 64;
    localparam int INST_W   = 32;
    localparam int STALL_CW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_valid;
    logic                if_ready;
    logic [PC_W-1:0]     if_pc;
    logic [INST_W-1:0]   if_inst;
    logic                if_fault;
    logic                flush;
    logic                id_valid;
    logic                id_ready;
    logic [PC_W-1:0]     id_pc;
    logic [INST_W-1:0]   id_inst;
    logic                id_fault;
    logic [1:0]          occupancy;
    logic [STALL_CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_id_pipe #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .STALL_CW (STALL_CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_fault  (if_fault),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_fault  (id_fault),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic f);
        if_valid = v;
        if_pc    = pc;
        if_inst  = pc[31:0] ^ 32'hA5A5_0000;
        if_fault = f;
    endtask

    // Expects the presented beat to be pc with its instruction encoding from drive().
    task automatic expect_beat(input string tag, input logic [63:0] pc, input logic [1:0] occ);
        logic [63:0] exp_inst;
        exp_inst = {32'h0, pc[31:0] ^ 32'hA5A5_0000};
        check({tag, ".valid"}, {63'h0, id_valid}, 64'h1);
        check({tag, ".pc"},    id_pc, pc);
        check({tag, ".inst"},  {32'h0, id_inst}, exp_inst);
        check({tag, ".occ"},   {62'h0, occupancy}, {62'h0, occ});
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, {63'h0, id_valid}, 64'h0);
        check({tag, ".inst"},  {32'h0, id_inst}, {32'h0, NOP});
        check({tag, ".fault"}, {63'h0, id_fault}, 64'h0);
        check({tag, ".occ"},   {62'h0, occupancy}, 64'h0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        drive(1'b0, 64'h0, 1'b0);
        tick();
        tick();
        expect_empty("reset");
        check("reset.pc",    id_pc, 64'h0);
        check("reset.rdy",   {63'h0, if_ready}, 64'h1);
        check("reset.stall", {60'h0, stall_cnt}, 64'h0);
        rst = 1'b0;
        tick();

        // T2 streaming
        id_ready = 1'b1;
        drive(1'b1, 64'h1000, 1'b0); tick(); expect_beat("s0", 64'h1000, 2'd1);
        drive(1'b1, 64'h1004, 1'b0); tick(); expect_beat("s1", 64'h1004, 2'd1);
        drive(1'b1, 64'h1008, 1'b0); tick(); expect_beat("s2", 64'h1008, 2'd1);
        drive(1'b0, 64'h0, 1'b0);    tick(); expect_empty("s3");
        check("s3.stall", {60'h0, stall_cnt}, 64'h0);

        // T3 backpressure
        id_ready = 1'b0;
        drive(1'b1, 64'h2000, 1'b0); tick(); expect_beat("b0", 64'h2000, 2'd1);
        check("b0.rdy", {63'h0, if_ready}, 64'h1);
        drive(1'b1, 64'h2004, 1'b0); tick(); expect_beat("b1", 64'h2000, 2'd2);
        check("b1.rdy", {63'h0, if_ready}, 64'h0);
        drive(1'b1, 64'h2008, 1'b0); tick(); expect_beat("b2", 64'h2000, 2'd2);
        check("b2.stall", {60'h0, stall_cnt}, 64'h2);
        id_ready = 1'b1;
        tick(); expect_beat("b3", 64'h2004, 2'd1);
        check("b3.rdy", {63'h0, if_ready}, 64'h1);
        tick(); expect_beat("b4", 64'h2008, 2'd1);
        drive(1'b0, 64'h0, 1'b0);
        tick(); expect_empty("b5");
        check("b5.stall", {60'h0, stall_cnt}, 64'h2);

        // T4 flush beats a simultaneous incoming beat
        id_ready = 1'b0;
        drive(1'b1, 64'h2800, 1'b0); tick();
        drive(1'b1, 64'h2804, 1'b0); tick(); expect_beat("f0", 64'h2800, 2'd2);
        flush = 1'b1;
        drive(1'b1, 64'h3000, 1'b0); tick(); expect_empty("f1");
        check("f1.stall", {60'h0, stall_cnt}, 64'h3);
        flush    = 1'b0;
        id_ready = 1'b1;
        drive(1'b0, 64'h0, 1'b0);    tick(); expect_empty("f2");
        check("f2.rdy", {63'h0, if_ready}, 64'h1);

        // T5 fault bit travels only with its own beat
        drive(1'b1, 64'h4000, 1'b1); tick(); expect_beat("x0", 64'h4000, 2'd1);
        check("x0.fault", {63'h0, id_fault}, 64'h1);
        drive(1'b1, 64'h4004, 1'b0); tick(); expect_beat("x1", 64'h4004, 2'd1);
        check("x1.fault", {63'h0, id_fault}, 64'h0);
        drive(1'b0, 64'h0, 1'b0);    tick(); expect_empty("x2");

        // T1 asynchronous reset with two beats held
        id_ready = 1'b0;
        drive(1'b1, 64'h5000, 1'b0); tick();
        drive(1'b1, 64'h5004, 1'b0); tick(); expect_beat("r0", 64'h5000, 2'd2);
        check("r0.stall", {60'h0, stall_cnt}, 64'h4);
        drive(1'b0, 64'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_empty("r1");
        check("r1.rdy",   {63'h0, if_ready}, 64'h1);
        check("r1.stall", {60'h0, stall_cnt}, 64'h0);
        #2 rst = 1'b0;
        tick(); expect_empty("r2");
        id_ready = 1'b1;
        drive(1'b1, 64'h6000, 1'b0); tick(); expect_beat("r3", 64'h6000, 2'd1);
        drive(1'b0, 64'h0, 1'b0);    tick(); expect_empty("r4");

        // T6 saturating stall counter
        id_ready = 1'b0;
        drive(1'b1, 64'h7000, 1'b0); tick();
        drive(1'b0, 64'h0, 1'b0);
        check("c0.stall", {60'h0, stall_cnt}, 64'h0);
        for (int i = 0; i < 14; i++) tick();
        check("c14.stall", {60'h0, stall_cnt}, 64'd14);
        for (int i = 0; i < 6; i++) tick();
        check("c20.stall", {60'h0, stall_cnt}, 64'd15);
        expect_beat("c20", 64'h7000, 2'd1);
        id_ready = 1'b1;
        tick(); expect_empty("c21");
        check("c21.stall", {60'h0, stall_cnt}, 64'd15);
        tick();
        check("c22.stall", {60'h0, stall_cnt}, 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
